// File: rtl/mips_cpu_run_ctrl_pkg.sv
// Shared types for the MIPS CPU run controller: FSM states and verdict codes.
package mips_cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_PASS    = 2'd0,
        FC_HANG    = 2'd1,
        FC_TIMEOUT = 2'd2
    } fail_code_t;

endpackage

// File: rtl/mips_cpu_pc_trace_buf.sv
// Ring buffer of the most recent retired PCs; read index 0 is the newest entry.
// Only instantiated when MIPS_CPU_RUN_CTRL_TRACE_EN is defined. DEPTH must be a power of 2.
module mips_cpu_pc_trace_buf #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [PC_W-1:0]          wr_pc_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [PC_W-1:0]          rd_pc_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [IDX_W-1:0] wptr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wptr_q] <= wr_pc_i;
            wptr_q        <= wptr_q + IDX_W'(1);
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of 2.
    assign rd_pc_o = mem_q[wptr_q - IDX_W'(1) - rd_idx_i];

endmodule

// File: rtl/mips_cpu_run_ctrl.sv
// Run controller for the MIPS CPU: sequences core reset, counts cycles/retires, latches a verdict.
// Optional PC trace ring buffer enabled by defining MIPS_CPU_RUN_CTRL_TRACE_EN.
//
//   state | meaning
//   IDLE  | after reset, core held in reset, waiting for start
//   RESET | core reset held for RST_CYCLES cycles
//   RUN   | core running, counters and end-of-program detectors active
//   DONE  | verdict latched, counters frozen, core held in reset
module mips_cpu_run_ctrl
    import mips_cpu_run_ctrl_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 3,
    parameter logic [PC_W-1:0] PASS_PC     = PC_W'(32'h0000_0008),
    parameter int              HANG_CYCLES = 16,
    parameter int              TIMEOUT     = 100000
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
    ,
    parameter int              TRACE_DEPTH = 8
`endif
) (
    input  logic             mips_cpu_clk,
    input  logic             mips_cpu_reset,
    input  logic             start,
    output logic             cpu_reset,
    input  logic             pc_valid,
    input  logic [PC_W-1:0]  pc_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [PC_W-1:0]                trace_pc
`endif
);

    localparam int               RST_W        = $clog2(RST_CYCLES + 1);
    localparam int               HANG_W       = $clog2(HANG_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LOAD     = RST_W'(RST_CYCLES - 1);
    localparam logic [HANG_W-1:0] HANG_LIMIT  = HANG_W'(HANG_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    logic              cpu_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    fail_code_t        fail_code_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  retire_cnt_q;
    logic [HANG_W-1:0] hang_cnt_q;
    logic [HANG_W-1:0] hang_cnt_d;
    logic [PC_W-1:0]   last_pc_q;
    logic [RST_W-1:0]  rst_cnt_q;

    logic pass_hit;
    logic hang_hit;
    logic timeout_hit;

    // A cleared last_pc with a zero count gives 1 on the first sample whatever the PC is.
    always_comb begin
        hang_cnt_d = hang_cnt_q;
        if (pc_valid) begin
            hang_cnt_d = (pc_in == last_pc_q) ? hang_cnt_q + HANG_W'(1) : HANG_W'(1);
        end
        pass_hit    = pc_valid && (pc_in == PASS_PC);
        hang_hit    = pc_valid && (hang_cnt_d == HANG_LIMIT);
        timeout_hit = (cycle_cnt_q == TIMEOUT_LAST);
    end

    always_ff @(posedge mips_cpu_clk) begin
        if (!mips_cpu_reset) begin
            state_q      <= IDLE;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= FC_PASS;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            hang_cnt_q   <= '0;
            last_pc_q    <= '0;
            rst_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RESET;
                        cpu_reset_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_code_q  <= FC_PASS;
                        cycle_cnt_q  <= '0;
                        retire_cnt_q <= '0;
                        hang_cnt_q   <= '0;
                        last_pc_q    <= '0;
                        rst_cnt_q    <= RST_LOAD;
                    end
                end
                RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_q     <= RUN;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RST_W'(1);
                    end
                end
                RUN: begin
                    if (cycle_cnt_q != '1) begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                    if (pc_valid && (retire_cnt_q != '1)) begin
                        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
                    end
                    if (pc_valid) begin
                        last_pc_q <= pc_in;
                    end
                    hang_cnt_q <= hang_cnt_d;
                    if (pass_hit || hang_hit || timeout_hit) begin
                        state_q     <= DONE;
                        cpu_reset_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= pass_hit;
                        if (pass_hit) begin
                            fail_code_q <= FC_PASS;
                        end else if (hang_hit) begin
                            fail_code_q <= FC_HANG;
                        end else begin
                            fail_code_q <= FC_TIMEOUT;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_code  = fail_code_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;

`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
    logic trace_clr;
    logic trace_wr;

    assign trace_clr = start && ((state_q == IDLE) || (state_q == DONE));
    assign trace_wr  = (state_q == RUN) && pc_valid;

    mips_cpu_pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clk_i    (mips_cpu_clk),
        .rst_n_i  (mips_cpu_reset),
        .clr_i    (trace_clr),
        .wr_en_i  (trace_wr),
        .wr_pc_i  (pc_in),
        .rd_idx_i (trace_idx),
        .rd_pc_o  (trace_pc)
    );
`endif

endmodule

// File: tb/tb_mips_cpu_run_ctrl.sv
// Self-checking bench for mips_cpu_run_ctrl: directed scenarios plus randomized runs
// checked against a queue-based reference model of the run rules.
module tb_mips_cpu_run_ctrl;

    localparam int          PC_W        = 32;
    localparam int          CNT_W       = 32;
    localparam int          RST_CYCLES  = 3;
    localparam int          HANG_CYCLES = 16;
    localparam int          TIMEOUT     = 100;
    localparam logic [31:0] PASS_PC     = 32'h0000_0008;
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
    localparam int          TRACE_DEPTH = 8;
    localparam int          TIDX_W      = $clog2(TRACE_DEPTH);
`endif

    logic             mips_cpu_clk = 1'b0;
    logic             mips_cpu_reset;
    logic             start;
    logic             cpu_reset;
    logic             pc_valid;
    logic [PC_W-1:0]  pc_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
    logic [TIDX_W-1:0] trace_idx;
    logic [PC_W-1:0]   trace_pc;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int              m_cycles;
    int              m_retired;
    logic [PC_W-1:0] m_pcs[$];
    bit              m_end;
    bit              m_pass;
    logic [1:0]      m_fc;
    logic [32:0]     stim_q[$];

    always #5 mips_cpu_clk = ~mips_cpu_clk;

    mips_cpu_run_ctrl #(
        .PC_W        (PC_W),
        .CNT_W       (CNT_W),
        .RST_CYCLES  (RST_CYCLES),
        .PASS_PC     (PASS_PC),
        .HANG_CYCLES (HANG_CYCLES),
        .TIMEOUT     (TIMEOUT)
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
        ,
        .TRACE_DEPTH (TRACE_DEPTH)
`endif
    ) dut (
        .mips_cpu_clk   (mips_cpu_clk),
        .mips_cpu_reset (mips_cpu_reset),
        .start          (start),
        .cpu_reset      (cpu_reset),
        .pc_valid       (pc_valid),
        .pc_in          (pc_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_code      (fail_code),
        .cycle_cnt      (cycle_cnt),
        .retire_cnt     (retire_cnt)
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
        ,
        .trace_idx      (trace_idx),
        .trace_pc       (trace_pc)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge mips_cpu_clk);
        #1;
    endtask

    function automatic int m_run_len();
        int n = 0;
        for (int i = m_pcs.size() - 1; i >= 0; i--) begin
            if (m_pcs[i] != m_pcs[m_pcs.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic m_clear();
        m_cycles  = 0;
        m_retired = 0;
        m_pcs.delete();
        m_end  = 1'b0;
        m_pass = 1'b0;
        m_fc   = 2'd0;
    endtask

    // One RUN cycle of the reference: counters, retired-PC history, verdict with priority.
    task automatic m_step(input logic v, input logic [PC_W-1:0] p);
        m_cycles++;
        if (v) begin
            m_retired++;
            m_pcs.push_back(p);
        end
        m_end  = 1'b0;
        m_pass = 1'b0;
        if (v && p == PASS_PC) begin
            m_end = 1'b1; m_pass = 1'b1; m_fc = 2'd0;
        end else if (v && m_run_len() >= HANG_CYCLES) begin
            m_end = 1'b1; m_fc = 2'd1;
        end else if (m_cycles == TIMEOUT) begin
            m_end = 1'b1; m_fc = 2'd2;
        end
    endtask

`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
    function automatic logic [PC_W-1:0] m_trace(input int idx);
        if (idx < m_pcs.size()) return m_pcs[m_pcs.size() - 1 - idx];
        return '0;
    endfunction

    task automatic check_trace();
        for (int i = 0; i < TRACE_DEPTH; i++) begin
            trace_idx = TIDX_W'(i);
            #1;
            chk("trace_all", 64'(trace_pc), 64'(m_trace(i)));
        end
    endtask
`endif

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_clear();
        chk("start_done_clr", 64'(done), 64'd0);
        chk("start_pass_clr", 64'(pass), 64'd0);
        chk("start_fc_clr", 64'(fail_code), 64'd0);
        chk("start_cyc_clr", 64'(cycle_cnt), 64'd0);
        chk("start_ret_clr", 64'(retire_cnt), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        chk("rst_hold", 64'(cpu_reset), 64'd1);
        for (int i = 1; i < RST_CYCLES; i++) begin
            start = ($urandom_range(0, 2) == 0);
            tick();
            start = 1'b0;
            chk("rst_hold", 64'(cpu_reset), 64'd1);
            chk("rst_busy", 64'(busy), 64'd1);
        end
        tick();
        chk("rst_release", 64'(cpu_reset), 64'd0);
        chk("run_busy", 64'(busy), 64'd1);
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
        check_trace();
`endif
    endtask

    // Play stim_q into RUN until the model sees an end condition, then check the frozen DONE state.
    task automatic run_stim(input bit inject_start);
        bit          ended = 1'b0;
        logic [31:0] cyc_f;
        logic [31:0] ret_f;
        for (int c = 0; c < TIMEOUT + 4 && !ended; c++) begin
            logic            v;
            logic [PC_W-1:0] p;
            v = 1'b0;
            p = '0;
            if (c < stim_q.size()) {v, p} = stim_q[c];
            pc_valid = v;
            pc_in    = p;
            start    = inject_start && ($urandom_range(0, 9) == 0);
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
            trace_idx = TIDX_W'($urandom_range(0, TRACE_DEPTH - 1));
`endif
            m_step(v, p);
            tick();
            start    = 1'b0;
            pc_valid = 1'b0;
            chk("done", 64'(done), 64'(m_end));
            chk("busy", 64'(busy), 64'(!m_end));
            chk("cpu_reset", 64'(cpu_reset), 64'(m_end));
            chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
            chk("retire_cnt", 64'(retire_cnt), 64'(m_retired));
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
            chk("trace_pc", 64'(trace_pc), 64'(m_trace(int'(trace_idx))));
`endif
            if (m_end) begin
                chk("pass", 64'(pass), 64'(m_pass));
                chk("fail_code", 64'(fail_code), 64'(m_fc));
                ended = 1'b1;
            end
        end
        cyc_f = 32'(m_cycles);
        ret_f = 32'(m_retired);
        for (int k = 0; k < 2; k++) begin
            pc_valid = 1'b1;
            pc_in    = 32'h300 + ($urandom_range(0, 3) << 2);
            tick();
            pc_valid = 1'b0;
            chk("done_hold", 64'(done), 64'd1);
            chk("cyc_frozen", 64'(cycle_cnt), 64'(cyc_f));
            chk("ret_frozen", 64'(retire_cnt), 64'(ret_f));
            chk("done_cpu_reset", 64'(cpu_reset), 64'd1);
        end
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
        check_trace();
`endif
    endtask

    task automatic gen_random(input int mode);
        logic [PC_W-1:0] last;
        last = 32'h40;
        stim_q.delete();
        for (int i = 0; i < TIMEOUT; i++) begin
            logic            v;
            logic [PC_W-1:0] p;
            v = ($urandom_range(0, 3) != 0);
            p = last;
            case (mode)
                0: if ($urandom_range(0, 29) == 0) p = 32'h100 + ($urandom_range(0, 3) << 2);
                1: begin
                    if ($urandom_range(0, 29) == 0) p = PASS_PC;
                    else if ($urandom_range(0, 4) == 0) p = 32'h100 + ($urandom_range(0, 7) << 2);
                end
                default: p = 32'h200 + 32'(i << 2);
            endcase
            last = p;
            stim_q.push_back({v, p});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        mips_cpu_reset = 1'b0;
        start          = 1'b0;
        pc_valid       = 1'b0;
        pc_in          = '0;
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
        trace_idx      = '0;
`endif
        repeat (3) tick();
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fc", 64'(fail_code), 64'd0);
        chk("rst_cyc", 64'(cycle_cnt), 64'd0);
        chk("rst_ret", 64'(retire_cnt), 64'd0);
        mips_cpu_reset = 1'b1;
        pc_valid = 1'b1;
        pc_in    = PASS_PC;
        tick();
        pc_valid = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // PCs 0,4,8 -> pass after 3 cycles
        launch();
        stim_q.delete();
        stim_q.push_back({1'b1, 32'h0});
        stim_q.push_back({1'b1, 32'h4});
        stim_q.push_back({1'b1, 32'h8});
        run_stim(1'b0);
        chk("t2_pass", 64'(pass), 64'd1);
        chk("t2_retire", 64'(retire_cnt), 64'd3);

        // 16 samples of one PC with gaps -> hang on the 16th
        launch();
        stim_q.delete();
        for (int i = 0; i < HANG_CYCLES; i++) begin
            stim_q.push_back({1'b1, 32'h40});
            repeat ($urandom_range(1, 3)) stim_q.push_back({1'b0, 32'h40});
        end
        run_stim(1'b0);
        chk("t3_fc", 64'(fail_code), 64'd1);
        chk("t3_retire", 64'(retire_cnt), 64'(HANG_CYCLES));

        // no retires -> timeout
        launch();
        stim_q.delete();
        run_stim(1'b0);
        chk("t4_fc", 64'(fail_code), 64'd2);
        chk("t4_cyc", 64'(cycle_cnt), 64'(TIMEOUT));

        // PASS_PC on the timeout cycle -> pass wins
        launch();
        stim_q.delete();
        for (int i = 0; i < TIMEOUT - 1; i++) stim_q.push_back({1'b0, 32'h0});
        stim_q.push_back({1'b1, PASS_PC});
        run_stim(1'b0);
        chk("t5_pass", 64'(pass), 64'd1);
        chk("t5_fc", 64'(fail_code), 64'd0);

        // reset mid-run aborts to IDLE
        launch();
        for (int c = 0; c < 5; c++) begin
            pc_valid = 1'b1;
            pc_in    = 32'h200 + 32'(c << 2);
            m_step(pc_valid, pc_in);
            tick();
            chk("mid_cyc", 64'(cycle_cnt), 64'(m_cycles));
        end
        pc_valid       = 1'b0;
        mips_cpu_reset = 1'b0;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("abort_cyc", 64'(cycle_cnt), 64'd0);
        chk("abort_ret", 64'(retire_cnt), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        mips_cpu_reset = 1'b1;
        tick();
        chk("abort_idle", 64'(busy), 64'd0);

        // ten PCs 0x10..0x34 then timeout; trace keeps the newest eight
        launch();
        stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back({1'b1, 32'h10 + 32'(i << 2)});
        run_stim(1'b0);
        chk("t6_fc", 64'(fail_code), 64'd2);
`ifdef MIPS_CPU_RUN_CTRL_TRACE_EN
        trace_idx = TIDX_W'(0);
        #1;
        chk("t6_trace0", 64'(trace_pc), 64'h34);
        trace_idx = TIDX_W'(TRACE_DEPTH - 1);
        #1;
        chk("t6_trace7", 64'(trace_pc), 64'h18);
`endif

        for (int r = 0; r < 24; r++) begin
            gen_random(r % 3);
            launch();
            run_stim(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
